// File: rtl/cpa_slice_sequencer_if.sv
// Request/response bundle for the sliced wide adder.
// Optional port sub exists only when CPA_SEQ_SUB_EN is defined.
interface cpa_slice_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CPA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
`ifdef CPA_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef CPA_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/cpa_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder reusing one 8-bit Sklansky CPA, LS slice first.
// Define CPA_SEQ_SUB_EN to add the sub input (a - b, cout=1 means no borrow).
module cpa_slice_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    cpa_slice_sequencer_if.slave bus
);
    localparam int unsigned SLICES = WIDTH / 8;
    localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cpa_slice_sequencer: WIDTH must be a multiple of 8 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [WIDTH-1:0]   sum_q, sum_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic               carry_q, carry_n;
    logic               cout_q, cout_n;
    logic               in_ready_q, in_ready_n;
    logic               out_valid_q, out_valid_n;
    logic               busy_q, busy_n;

    logic [7:0]         cpa_a, cpa_b, cpa_sum;
    logic               cpa_cout;
    logic [7:0]         slice_sum;
    logic               slice_cout;

    // Shared 8-bit Sklansky prefix CPA (no carry-in)
    always_comb begin
        logic [7:0] g, p, p0;
        p0 = cpa_a ^ cpa_b;
        g  = cpa_a & cpa_b;
        p  = p0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            for (int i = 0; i < 8; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> lvl) << lvl) - 1]);
                    p[i] = p[i] & p[((i >> lvl) << lvl) - 1];
                end
            end
        end
        cpa_sum  = p0 ^ {g[6:0], 1'b0};
        cpa_cout = g[7];
    end

    // Slice select and carry injection through a local incrementer
    always_comb begin
        cpa_a      = a_q[8*idx_q +: 8];
        cpa_b      = b_q[8*idx_q +: 8];
        slice_sum  = cpa_sum + 8'(carry_q);
        slice_cout = cpa_cout | ((&cpa_sum) & carry_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            sum_q       <= sum_n;
            idx_q       <= idx_n;
            carry_q     <= carry_n;
            cout_q      <= cout_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        a_n         = a_q;
        b_n         = b_q;
        sum_n       = sum_q;
        idx_n       = idx_q;
        carry_n     = carry_q;
        cout_n      = cout_q;
        in_ready_n  = in_ready_q;
        out_valid_n = out_valid_q;
        busy_n      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_n        = bus.a;
                    idx_n      = '0;
`ifdef CPA_SEQ_SUB_EN
                    b_n        = bus.sub ? ~bus.b : bus.b;
                    carry_n    = bus.sub ? 1'b1 : bus.cin;
`else
                    b_n        = bus.b;
                    carry_n    = bus.cin;
`endif
                    state_n    = RUN;
                    in_ready_n = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            RUN: begin
                sum_n[8*idx_q +: 8] = slice_sum;
                carry_n             = slice_cout;
                idx_n               = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(SLICES - 1)) begin
                    cout_n      = slice_cout;
                    idx_n       = '0;
                    state_n     = DONE;
                    busy_n      = 1'b0;
                    out_valid_n = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
                busy_n      = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_cpa_slice_sequencer.sv
// Directed bench for cpa_slice_sequencer (WIDTH=32); sub tests need CPA_SEQ_SUB_EN.
module tb_cpa_slice_sequencer;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_acc = -100;

    cpa_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

    cpa_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction: accept, wait for result, optional stall, handshake out
    task automatic run_add(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                           input int stall, input bit scramble,
                           input logic [31:0] es, input logic ec, input string tag);
        int n;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_interval_ok"}, 64'((cyc - last_acc) >= 6), 64'd1);
        last_acc     = cyc;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = ci;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (scramble) begin
                bus.a   = $urandom;
                bus.b   = $urandom;
                bus.cin = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_sum"}, 64'(bus.sum), 64'(es));
        check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_stall_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_stall_sum"}, {31'd0, bus.cout, bus.sum}, {31'd0, ec, es});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [32:0] model;
        logic [31:0] ra, rb;
        logic        rc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef CPA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", {31'd0, bus.cout, bus.sum}, 64'd0);
        @(negedge clk);

        run_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, 32'h0000_0000, 1'b1, "ripple");
        run_add(32'h1234_5678, 32'h0FED_CBA8, 1'b0, 3, 1'b0, 32'h2222_2220, 1'b0, "stall");
        repeat (2) @(negedge clk);
        run_add(32'h8000_0000, 32'h8000_0000, 1'b0, 1, 1'b1, 32'h0000_0000, 1'b1, "scramble");
        repeat (2) @(negedge clk);

        // Abort with reset while slice 2 is next
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h1111_1111;
        bus.cin      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy_low", 64'(bus.busy), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        repeat (5) @(negedge clk);
        run_add(32'd1, 32'd1, 1'b0, 0, 1'b0, 32'd2, 1'b0, "after_abort");

        // Back-to-back random pairs with random gaps
        for (int k = 0; k < 20; k++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_add(ra, rb, rc, $urandom_range(0, 2), 1'b0, model[31:0], model[32], "rand");
        end

`ifdef CPA_SEQ_SUB_EN
        bus.sub = 1'b1;
        repeat (6) @(negedge clk);
        run_add(32'd5, 32'd7, 1'b0, 0, 1'b0, 32'hFFFF_FFFE, 1'b0, "sub_neg");
        repeat (6) @(negedge clk);
        run_add(32'd7, 32'd5, 1'b0, 0, 1'b0, 32'd2, 1'b1, "sub_pos");
        bus.sub = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpa_slice_sequencer.md
Name: cpa_slice_sequencer

Overview:
- Multi-cycle wide adder. It time-multiplexes one instance of the team's generated 8-bit Sklansky prefix CPA (ports a[7:0], b[7:0], sum[7:0], cout; no carry-in) across the slices of a WIDTH-bit operand pair, least significant slice first.
- It owns slice selection, carry chaining, carry-in injection, result assembly and the valid/ready handshakes.
- Sits between a multiplier's final partial-product stage (or any wide-add client) and the shared CPA, trading latency for area.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 8 and at least 8; elaboration error otherwise.
- SLICES, WIDTH/8, derived local constant (not overridable); number of CPA passes.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept a request
- a  input  WIDTH  operand A, captured on accept
- b  input  WIDTH  operand B, captured on accept
- cin  input  1  carry-in, captured on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of MSB slice
- busy  output  1  high in RUN state

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice index=0, carry register=0.
- Reset asserted mid-operation aborts: the in-flight result is discarded, nothing is emitted, and the block is back in IDLE on the next cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: capture a, b, cin; set idx=0, carry=cin; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the CPA sees a[8*idx+:8] and b[8*idx+:8] from the captured operands.
  - Slice result = CPA sum + carry, computed with a local 8-bit incrementer.
  - Slice carry-out = cpa_cout | (cpa_sum==8'hFF & carry).
  - At each edge, the slice result is written into sum[8*idx+:8], carry <= slice carry-out, idx increments.
  - The edge that processes idx=SLICES-1 writes cout and moves to DONE.
  - Slice k is therefore written at edge E(k+1); out_valid rises after edge E(SLICES). Latency is SLICES cycles from the accept edge (4 for WIDTH=32).
- DONE:
  - out_valid=1; sum and cout are held stable until out_ready=1.
  - On out_valid&out_ready, return to IDLE next cycle.
  - No accept in the same cycle (in_ready=0 in DONE).
  - Throughput: one result per SLICES+2 cycles when out_ready is held at 1.
- Inputs a, b and cin are ignored outside the accept cycle; later changes do not affect an in-flight add.
- in_valid while not ready: the request is not taken; the requester must hold it.
- WIDTH=8: single pass; DONE after one cycle.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned.

Optional Feature:
- Macro CPA_SEQ_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured on accept.
  - When sub=1, B is captured as ~b and the initial carry is forced to 1, ignoring cin. Result = a - b; cout=1 means no borrow.
- Undefined: port sub is absent; add-only behaviour as above.

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; out_valid rises exactly 4 cycles after the accept edge (full carry ripple across all slices via the incrementer path).
- a=0x12345678, b=0x0FEDCBA8, cin=0, out_ready held 0 for 3 cycles -> sum=0x22222220, cout=0; sum and cout stable and out_valid high throughout the stall; in_ready=0 until the cycle after out_ready=1.
- Change a and b every cycle during RUN after accepting a=0x80000000, b=0x80000000 -> result unaffected: sum=0, cout=1.
- Assert rst for 1 cycle while idx=2 -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0; a following add of 1+1 returns 2.
- Back-to-back: 20 random operand pairs with random in_valid/out_ready gaps -> every result matches a+b+cin; no result lost or duplicated; interval ≥6 cycles.
- With CPA_SEQ_SUB_EN: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.
